uart_rx_fifo: RTL and testbench

- Receive-side byte buffer between the uart block and the CPU memory-mapped I/O decoder, all in the `clki` domain.
- Drains the uart's single-byte `rx_new`/`rx_data` holding register into a circular FIFO, so bytes arriving while the CPU is busy are not lost.
- Exposes to the address decoder a head byte, a pop strobe and a 16-bit status word, for I/O addresses 0x0001 (data) and 0x0002 (status).
- Bus strobes originate from the slower `cpu_clk` logic. The block therefore acts on their rising edges, never their levels.

---
 rtl/uart_rx_fifo_pkg.sv | 26 ++
 rtl/uart_rx_fifo_mem_2p.sv | 32 +++
 rtl/uart_rx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// ============================================================================
//  Module      : uart_rx_fifo_pkg
//  Description : Shared constants for the uart receive FIFO and its decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_fifo_pkg;

   // Bit positions inside the 16-bit status word
   localparam int c_STS_NEMPTY    = 0;
   localparam int c_STS_FULL      = 1;
   localparam int c_STS_OVF       = 2;
   localparam int c_STS_COUNT_LSB = 8;
   localparam int c_STS_IRQ       = 15;

   localparam logic [1:0] c_ST_IDLE     = 2'd0;
   localparam logic [1:0] c_ST_ACK      = 2'd1;
   localparam logic [1:0] c_ST_WAIT_LOW = 2'd2;

   localparam logic [15:0] c_ADDR_DATA   = 16'h0001;
   localparam logic [15:0] c_ADDR_STATUS = 16'h0002;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_mem_2p.sv
// ============================================================================
//  Module      : fifo_mem_2p
//  Description : Inferred dual-port RAM, synchronous write, asynchronous read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_mem_2p #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   output logic [WIDTH-1:0]      rdata_o
);

   logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Uart receive byte FIFO with edge-triggered bus pop/clear.
//                Optional fill-level interrupt: define UART_RX_FIFO_IRQ_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int IRQ_LEVEL  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_new,
   input  logic [7:0]  rx_data,
   output logic        rx_ack,
   input  logic        bus_rd,
   input  logic        bus_clr,
   output logic [7:0]  rd_data,
   output logic [15:0] status,
   output logic        irq
);

   localparam logic [DEPTH_LOG2:0] c_FULL_CNT = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
   localparam logic [DEPTH_LOG2:0] c_CNT_ONE  = (DEPTH_LOG2+1)'(1);

   generate
      if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 5 || IRQ_LEVEL < 1 || IRQ_LEVEL > 2**DEPTH_LOG2) begin : g_bad_param
         $error("uart_rx_fifo: DEPTH_LOG2 or IRQ_LEVEL out of range");
      end
   endgenerate

   logic [1:0]            state_q, state_d;
   logic                  rx_ack_q, rx_ack_d;
   logic                  bus_rd_q, bus_clr_q;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [7:0]            rd_data_q, rd_data_d;
   logic [15:0]           status_q, status_d;
   logic                  irq_q, irq_d;

   logic                  w_push_req, w_push, w_pop, w_full, w_nempty;
   logic                  w_pop_edge, w_clr_edge;
   logic [7:0]            w_mem_rdata;

   // Ingest FSM: one push per uart byte, regardless of how long rx_new stays high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= c_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_IDLE:     if (rx_new)  state_d = c_ST_ACK;
         c_ST_ACK:                   state_d = c_ST_WAIT_LOW;
         c_ST_WAIT_LOW: if (!rx_new) state_d = c_ST_IDLE;
         default:                    state_d = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_push_req = (state_q == c_ST_IDLE) && rx_new;
      rx_ack_d   = w_push_req;
   end

   assign w_full     = (count_q == c_FULL_CNT);
   assign w_nempty   = (count_q != '0);
   assign w_pop_edge = bus_rd  & ~bus_rd_q;
   assign w_clr_edge = bus_clr & ~bus_clr_q;
   assign w_pop      = w_pop_edge & w_nempty;
   // A full FIFO can still accept a byte when a pop frees a slot in the same cycle
   assign w_push     = w_push_req & (~w_full | w_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(w_push);
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(w_pop);
      count_d  = count_q;
      if (w_push && !w_pop) begin
         count_d = count_q + c_CNT_ONE;
      end else if (w_pop && !w_push) begin
         count_d = count_q - c_CNT_ONE;
      end
      ovf_d = ovf_q;
      if (w_push_req && w_full && !w_pop) begin
         ovf_d = 1'b1;
      end else if (w_clr_edge) begin
         ovf_d = 1'b0;
      end
   end

`ifdef UART_RX_FIFO_IRQ_EN
   localparam logic [DEPTH_LOG2:0] c_IRQ_CNT = (DEPTH_LOG2+1)'(IRQ_LEVEL);
   assign irq_d = (count_q >= c_IRQ_CNT) | ovf_q;
`else
   assign irq_d = 1'b0;
`endif

   always_comb begin
      rd_data_d = w_nempty ? w_mem_rdata : 8'h00;
      status_d  = '0;
      status_d[c_STS_NEMPTY] = w_nempty;
      status_d[c_STS_FULL]   = w_full;
      status_d[c_STS_OVF]    = ovf_q;
      status_d[c_STS_COUNT_LSB +: DEPTH_LOG2+1] = count_q;
      status_d[c_STS_IRQ]    = irq_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ack_q  <= 1'b0;
         bus_rd_q  <= 1'b0;
         bus_clr_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         rd_data_q <= 8'h00;
         status_q  <= 16'h0000;
         irq_q     <= 1'b0;
      end else begin
         rx_ack_q  <= rx_ack_d;
         bus_rd_q  <= bus_rd;
         bus_clr_q <= bus_clr;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         rd_data_q <= rd_data_d;
         status_q  <= status_d;
         irq_q     <= irq_d;
      end
   end

   fifo_mem_2p #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_mem (
      .clk     (clk),
      .we_i    (w_push),
      .waddr_i (wr_ptr_q),
      .wdata_i (rx_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (w_mem_rdata)
   );

   assign rx_ack  = rx_ack_q;
   assign rd_data = rd_data_q;
   assign status  = status_q;
   assign irq     = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_new;
   logic [7:0]  rx_data;
   logic        rx_ack;
   logic        bus_rd;
   logic        bus_clr;
   logic [7:0]  rd_data;
   logic [15:0] status;
   logic        irq;

   int errors = 0;
   int checks = 0;
   int ack_cnt = 0;

   byte unsigned q[$];
   bit           m_ovf;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .DEPTH_LOG2 (4),
      .IRQ_LEVEL  (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rx_new  (rx_new),
      .rx_data (rx_data),
      .rx_ack  (rx_ack),
      .bus_rd  (bus_rd),
      .bus_clr (bus_clr),
      .rd_data (rd_data),
      .status  (status),
      .irq     (irq)
   );

   function automatic logic exp_irq();
`ifdef UART_RX_FIFO_IRQ_EN
      return (q.size() >= 8) || m_ovf;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [15:0] exp_status();
      int n = q.size();
      logic [15:0] s = '0;
      s[0]    = (n != 0);
      s[1]    = (n == 16);
      s[2]    = m_ovf;
      s[12:8] = n[4:0];
      s[15]   = exp_irq();
      return s;
   endfunction

   function automatic logic [7:0] exp_head();
      return (q.size() != 0) ? q[0] : 8'h00;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, " rd_data"}, {8'h00, rd_data}, {8'h00, exp_head()});
      check({tag, " status"},  status, exp_status());
      check({tag, " irq"},     {15'h0, irq}, {15'h0, exp_irq()});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rx_ack === 1'b1) ack_cnt++;
   endtask

   task automatic send(input logic [7:0] b, input int hold);
      int a0 = ack_cnt;
      rx_data = b;
      rx_new  = 1'b1;
      repeat (hold) tick();
      rx_new = 1'b0;
      tick();
      tick();
      if (q.size() < 16) q.push_back(b);
      else               m_ovf = 1'b1;
      check("rx_ack pulses per byte", 16'(ack_cnt - a0), 16'd1);
   endtask

   task automatic pop_once();
      bus_rd = 1'b1;
      tick();
      bus_rd = 1'b0;
      tick();
      if (q.size() != 0) void'(q.pop_front());
   endtask

   task automatic clear_ovf();
      bus_clr = 1'b1;
      tick();
      bus_clr = 1'b0;
      tick();
      m_ovf = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rx_new = 1'b0; rx_data = 8'h00; bus_rd = 1'b0; bus_clr = 1'b0;
      m_ovf = 1'b0;
      tick();
      tick();
      check("reset rx_ack", {15'h0, rx_ack}, 16'h0000);
      check("reset status", status, 16'h0000);
      check("reset rd_data", {8'h00, rd_data}, 16'h0000);
      check("reset irq", {15'h0, irq}, 16'h0000);
      rst = 1'b0;
      tick();

      // Three bytes, then drain them
      send(8'h41, 5);
      send(8'h42, 5);
      send(8'h43, 5);
      check("three bytes status", status, 16'h0301 | {exp_irq(), 15'h0});
      check_state("three bytes");
      for (int i = 0; i < 3; i++) begin
         check("three bytes head", {8'h00, rd_data}, {8'h00, 8'(8'h41 + i)});
         pop_once();
      end
      check("drained status", status, 16'h0000);
      check("drained rd_data", {8'h00, rd_data}, 16'h0000);

      // Overflow: 17 bytes with no reads
      for (int i = 1; i <= 17; i++) send(8'(i), int'($urandom_range(2, 4)));
      check("overflow status", status[14:0], 15'h1007);
      check_state("overflow");
      clear_ovf();
      check("ovf cleared status", status[14:0], 15'h1003);
      check_state("ovf cleared");

      // Push and pop in the same cycle on a full FIFO
      rx_data = 8'hAA; rx_new = 1'b1; bus_rd = 1'b1;
      tick();
      bus_rd = 1'b0;
      void'(q.pop_front());
      q.push_back(8'hAA);
      repeat (3) tick();
      rx_new = 1'b0;
      tick();
      tick();
      check("full push+pop status", status[14:0], 15'h1003);
      check_state("full push+pop");
      while (q.size() != 0) begin
         check_state("full drain");
         pop_once();
      end
      check_state("after full drain");

      // Pop on empty is ignored; push and pop together on empty keeps the push
      pop_once();
      check_state("pop on empty");
      rx_data = 8'h5C; rx_new = 1'b1; bus_rd = 1'b1;
      tick();
      bus_rd = 1'b0;
      q.push_back(8'h5C);
      repeat (2) tick();
      rx_new = 1'b0;
      tick();
      tick();
      check("empty push+pop status", status, 16'h0101);
      check_state("empty push+pop");

      // Held read strobe pops once only
      send(8'($urandom), 3);
      send(8'($urandom), 3);
      bus_rd = 1'b1;
      repeat (40) tick();
      bus_rd = 1'b0;
      tick();
      void'(q.pop_front());
      check_state("held bus_rd");

      // Randomised traffic
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: send(8'($urandom), int'($urandom_range(2, 5)));
            3, 4:    pop_once();
            default: clear_ovf();
         endcase
         check_state("random");
      end

      // Async reset in the ACK state with five entries stored
      if (m_ovf) clear_ovf();
      while (q.size() > 5) pop_once();
      while (q.size() < 5) send(8'($urandom), 2);
      check_state("pre-reset");
      rx_data = 8'h99; rx_new = 1'b1;
      tick();
      check("ack before reset", {15'h0, rx_ack}, 16'h0001);
      #2 rst = 1'b1;
      #1;
      q.delete();
      m_ovf = 1'b0;
      check("async reset rx_ack", {15'h0, rx_ack}, 16'h0000);
      check("async reset status", status, 16'h0000);
      check("async reset rd_data", {8'h00, rd_data}, 16'h0000);
      check("async reset irq", {15'h0, irq}, 16'h0000);
      rx_new = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      send(8'h5A, 3);
      check("post-reset status", status, 16'h0101);
      check_state("post-reset");
      pop_once();
      check_state("post-reset drained");

`ifdef UART_RX_FIFO_IRQ_EN
      for (int i = 0; i < 7; i++) send(8'($urandom), 2);
      check("irq below level", {15'h0, irq}, 16'h0000);
      send(8'($urandom), 2);
      check("irq at level", {15'h0, irq}, 16'h0001);
      check("status irq bit", {15'h0, status[15]}, 16'h0001);
      pop_once();
      check("irq after pop", {15'h0, irq}, 16'h0000);
      check_state("irq after pop");
`else
      for (int i = 0; i < 8; i++) send(8'($urandom), 2);
      check("irq disabled", {15'h0, irq}, 16'h0000);
      check("status bit15 disabled", {15'h0, status[15]}, 16'h0000);
      check_state("irq disabled");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
